// File: rtl/acc_job_scheduler.sv
// rtl/acc_job_scheduler.sv - round-robin job scheduler sharing one ap_ctrl_hs accelerator
module acc_job_scheduler #(
    parameter int NREQ  = 4,
    parameter int ARG_W = 32,
    parameter int RES_W = 32,
    parameter int TMO_W = 16,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*ARG_W-1:0]   req_arg,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    acc_ap_start,
    input  logic                    acc_ap_ready,
    input  logic                    acc_ap_done,
    input  logic                    acc_ap_idle,
    output logic [ARG_W-1:0]        acc_arg,
    input  logic [RES_W-1:0]        acc_ret,
    input  logic [TMO_W-1:0]        tmo_limit,
    output logic                    err_sticky,
    output logic [31:0]             job_count,
    output logic [31:0]             busy_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic [ID_W:0]     cand;
    logic              tmo_hit;

    // Walk candidates from farthest to nearest after last_grant so the nearest
    // valid requester is the one left standing.
    always_comb begin
        grant_id    = '0;
        grant_found = |req_valid;
        cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(k + 1);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (req_valid[cand[ID_W-1:0]]) begin
                grant_id = cand[ID_W-1:0];
            end
        end
    end

    assign req_ready = (state == S_IDLE && !reset && grant_found) ? (NREQ'(1) << grant_id) : '0;
    assign tmo_hit   = (tmo_limit != '0) && (tmo_cnt == tmo_limit - TMO_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            last_grant   <= ID_W'(NREQ - 1);
            tmo_cnt      <= '0;
            acc_ap_start <= 1'b0;
            acc_arg      <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            err_sticky   <= 1'b0;
            job_count    <= '0;
            busy_cycles  <= '0;
        end else begin
            if (state == S_START || state == S_WAIT) begin
                busy_cycles <= busy_cycles + 32'd1;
                if (tmo_cnt != '1) begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        acc_arg      <= req_arg[grant_id*ARG_W +: ARG_W];
                        rsp_id       <= grant_id;
                        tmo_cnt      <= '0;
                        acc_ap_start <= 1'b1;
                        state        <= S_START;
                    end
                end

                // Completion beats the watchdog when both land in the same cycle.
                S_START: begin
                    if (acc_ap_done) begin
                        rsp_data     <= acc_ret;
                        rsp_err      <= 1'b0;
                        rsp_valid    <= 1'b1;
                        acc_ap_start <= 1'b0;
                        state        <= S_RESP;
                    end else if (tmo_hit) begin
                        rsp_data     <= '0;
                        rsp_err      <= 1'b1;
                        err_sticky   <= 1'b1;
                        rsp_valid    <= 1'b1;
                        acc_ap_start <= 1'b0;
                        state        <= S_RESP;
                    end else if (acc_ap_ready) begin
                        acc_ap_start <= 1'b0;
                        state        <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (acc_ap_done) begin
                        rsp_data  <= acc_ret;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (tmo_hit) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        err_sticky <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        job_count  <= job_count + 32'd1;
                        last_grant <= rsp_id;
                        state      <= rsp_err ? S_DRAIN : S_IDLE;
                    end
                end

                // A timed-out accelerator may still be running; wait it out.
                S_DRAIN: begin
                    if (acc_ap_idle) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_job_scheduler.sv
// tb/tb_acc_job_scheduler.sv - randomized self-checking bench for acc_job_scheduler
module tb_acc_job_scheduler;

    localparam int NREQ  = 4;
    localparam int ARG_W = 32;
    localparam int RES_W = 32;
    localparam int TMO_W = 16;
    localparam int ID_W  = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ARG_W-1:0] req_arg;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [RES_W-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  acc_ap_start;
    logic                  acc_ap_ready;
    logic                  acc_ap_done;
    logic                  acc_ap_idle;
    logic [ARG_W-1:0]      acc_arg;
    logic [RES_W-1:0]      acc_ret;
    logic [TMO_W-1:0]      tmo_limit;
    logic                  err_sticky;
    logic [31:0]           job_count;
    logic [31:0]           busy_cycles;

    acc_job_scheduler #(
        .NREQ (NREQ),
        .ARG_W(ARG_W),
        .RES_W(RES_W),
        .TMO_W(TMO_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_arg     (req_arg),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .acc_ap_start(acc_ap_start),
        .acc_ap_ready(acc_ap_ready),
        .acc_ap_done (acc_ap_done),
        .acc_ap_idle (acc_ap_idle),
        .acc_arg     (acc_arg),
        .acc_ret     (acc_ret),
        .tmo_limit   (tmo_limit),
        .err_sticky  (err_sticky),
        .job_count   (job_count),
        .busy_cycles (busy_cycles)
    );

    always #5 clock = ~clock;

    typedef enum {P_FREE, P_BUSY, P_RESP, P_DRAIN} phase_t;

    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    phase_t           ph = P_FREE;
    bit               pend [NREQ];
    logic [ARG_W-1:0] parg [NREQ];
    int               m_last = NREQ - 1;
    logic [31:0]      m_jobs = 0;
    logic [31:0]      m_busy = 0;
    bit               m_sticky = 0;
    int               j_id, j_t, j_end, j_rdy;
    bit               j_err;
    logic [ARG_W-1:0] j_arg;
    bit               a_busy = 0;
    int               a_cnt = 0, a_lat = 1, a_rdy = 1;
    logic [ARG_W-1:0] a_arg;
    int               refill_pct = 0, rrdy_pct = 100;
    bit               reset_req = 0, post_reset = 0, use_dir = 0;
    int               dir_lat, dir_lim, dir_rdy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic start_job(input int g);
        int lat, lim, rdy, r;
        j_id  = g;
        j_arg = parg[g];
        pend[g] = 1'b0;
        j_t   = cyc;
        if (use_dir) begin
            lat = dir_lat; lim = dir_lim; rdy = dir_rdy;
            use_dir = 1'b0;
        end else begin
            r   = $urandom_range(99);
            rdy = $urandom_range(2, 1);
            if (r < 55) begin
                lat = $urandom_range(6, rdy);
                lim = ($urandom_range(1) == 0) ? 0 : lat + $urandom_range(5, 1);
            end else if (r < 70) begin
                lat = $urandom_range(7, 3);
                lim = lat;
            end else begin
                lim = $urandom_range(8, 1);
                lat = lim + $urandom_range(6, 1);
            end
        end
        j_rdy = rdy;
        j_err = (lim != 0) && (lim < lat);
        j_end = j_err ? lim : lat;
        a_lat = lat;
        a_rdy = rdy;
        tmo_limit = TMO_W'(lim);
        ph = P_BUSY;
    endtask

    task automatic cycle();
        logic [NREQ-1:0] exp_rr;
        int  pick;
        bit  hs;
        @(negedge clock);
        cyc++;
        if (ph == P_BUSY && cyc == j_t + j_end + 1) begin
            ph = P_RESP;
            if (j_err) m_sticky = 1'b1;
        end

        if (post_reset) begin
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_acc_arg", acc_arg, 0);
            check("rst_rsp_err", rsp_err, 0);
            post_reset = 1'b0;
        end
        check("rsp_valid", rsp_valid, ph == P_RESP);
        if (ph == P_RESP) begin
            check("rsp_id", rsp_id, j_id);
            check("rsp_data", rsp_data, j_err ? 0 : RES_W'(j_arg * 2));
            check("rsp_err", rsp_err, j_err);
        end
        check("acc_ap_start", acc_ap_start,
              ph == P_BUSY && cyc >= j_t + 1 && cyc <= j_t + ((j_rdy < j_end) ? j_rdy : j_end));
        check("err_sticky", err_sticky, m_sticky);
        check("job_count", job_count, m_jobs);
        check("busy_cycles", busy_cycles, m_busy);

        // Accelerator: ready after a_rdy cycles, done after a_lat cycles, then idle.
        if (a_busy && a_cnt >= a_lat) a_busy = 1'b0;
        if (a_busy) begin
            a_cnt++;
        end else if (acc_ap_start === 1'b1) begin
            a_busy = 1'b1;
            a_cnt  = 1;
            a_arg  = acc_arg;
        end
        acc_ap_ready = a_busy && (a_cnt == a_rdy);
        acc_ap_done  = a_busy && (a_cnt == a_lat);
        acc_ret      = acc_ap_done ? RES_W'(a_arg * 2) : RES_W'($urandom);
        acc_ap_idle  = !a_busy;

        rsp_ready = ($urandom_range(99) < rrdy_pct);
        hs = (ph == P_RESP) && rsp_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(99) < refill_pct) begin
                pend[i] = 1'b1;
                parg[i] = $urandom;
            end
            req_valid[i] = pend[i];
            req_arg[i*ARG_W +: ARG_W] = pend[i] ? parg[i] : ARG_W'($urandom);
        end
        reset = reset_req;

        #1;
        exp_rr = '0;
        pick   = -1;
        if (ph == P_FREE && !reset_req) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (pick < 0 && pend[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
            end
        end
        if (pick >= 0) exp_rr[pick] = 1'b1;
        check("req_ready", req_ready, exp_rr);

        if (reset_req) begin
            ph = P_FREE; m_last = NREQ - 1; m_jobs = 0; m_busy = 0; m_sticky = 0;
            a_busy = 1'b0;
            post_reset = 1'b1;
        end else begin
            if (ph == P_BUSY && cyc >= j_t + 1) m_busy++;
            if (hs) begin
                m_jobs++;
                m_last = j_id;
                ph = j_err ? P_DRAIN : P_FREE;
            end else if (ph == P_DRAIN && acc_ap_idle) begin
                ph = P_FREE;
            end else if (pick >= 0) begin
                start_job(pick);
            end
        end
    endtask

    function automatic bit none_pending();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic settle();
        refill_pct = 0;
        rrdy_pct   = 100;
        for (int k = 0; k < 200 && !(ph == P_FREE && none_pending()); k++) cycle();
        check("settle_free", ph == P_FREE && none_pending(), 1);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_arg = '0; rsp_ready = 1'b0;
        acc_ap_ready = 1'b0; acc_ap_done = 1'b0; acc_ap_idle = 1'b1; acc_ret = '0; tmo_limit = '0;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; parg[i] = '0; end
        repeat (2) @(posedge clock);
        reset_req = 1'b1; cycle(); reset_req = 1'b0;

        // single job: arg 5, latency 4, returns 0x0A
        pend[0] = 1'b1; parg[0] = 32'h5;
        use_dir = 1'b1; dir_lat = 4; dir_lim = 0; dir_rdy = 1;
        repeat (10) cycle();
        check("single_job_count", job_count, 1);

        // ap_done on the same cycle the watchdog limit is reached
        settle();
        pend[3] = 1'b1; parg[3] = $urandom;
        use_dir = 1'b1; dir_lat = 5; dir_lim = 5; dir_rdy = 2;
        repeat (10) cycle();
        check("tie_sticky", err_sticky, 0);

        // response backpressure with another requester waiting
        settle();
        pend[1] = 1'b1; parg[1] = $urandom;
        use_dir = 1'b1; dir_lat = 2; dir_lim = 0; dir_rdy = 1;
        rrdy_pct = 0;
        repeat (3) cycle();
        pend[3] = 1'b1; parg[3] = $urandom;
        repeat (8) cycle();
        rrdy_pct = 100;
        settle();

        // watchdog timeout with a late done while draining
        pend[2] = 1'b1; parg[2] = $urandom;
        use_dir = 1'b1; dir_lat = 18; dir_lim = 10; dir_rdy = 1;
        cycle();
        pend[0] = 1'b1; parg[0] = $urandom;
        repeat (30) cycle();
        check("timeout_sticky", err_sticky, 1);
        settle();

        // all requesters continuously active
        refill_pct = 100; rrdy_pct = 100;
        repeat (80) cycle();
        settle();

        refill_pct = 30; rrdy_pct = 60;
        repeat (2500) cycle();
        settle();

        // reset while the accelerator is in WAIT
        pend[1] = 1'b1; parg[1] = $urandom;
        use_dir = 1'b1; dir_lat = 8; dir_lim = 0; dir_rdy = 1;
        cycle();
        for (int k = 0; k < 20 && !(ph == P_BUSY && cyc >= j_t + 2); k++) cycle();
        check("mid_reset_in_wait", ph == P_BUSY, 1);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        reset_req = 1'b1; cycle(); reset_req = 1'b0;
        pend[2] = 1'b1; parg[2] = $urandom;
        repeat (15) cycle();
        check("post_reset_job_count", job_count, 1);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL sim_timeout: got cycle %0d expected completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
